// File: rtl/kpn_channel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kpn_channel_fifo
// Brief    : Bounded in-order token channel for the KPN fabric; blocking
//            write/read through full/empty, optional reset-time initial tokens.
// Revision : 1.0 - initial release
// ============================================================================
module kpn_channel_fifo #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter int               INIT_TOKENS = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr,
    input  logic [WIDTH-1:0]             entry_1,
    input  logic                         rd,
    output logic [WIDTH-1:0]             output_1,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf,
    output logic                         unf
);

    localparam int              c_pw         = $clog2(DEPTH);
    localparam int              c_cw         = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_wp_init    = c_pw'(INIT_TOKENS % DEPTH);
    localparam logic [c_pw-1:0] c_ptr_one    = c_pw'(1);
    localparam logic [c_cw-1:0] c_count_init = c_cw'(INIT_TOKENS);
    localparam logic [c_cw-1:0] c_count_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_depth      = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wp;
    logic [c_pw-1:0]  r_rp;
    logic [c_cw-1:0]  r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic             w_wa;
    logic             w_ra;

    // Status comes from the registered count only, never from wr/rd.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_wa    = wr & ~w_full;
    assign w_ra    = rd & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < INIT_TOKENS) begin
                    r_mem[i] <= INIT_VALUE;
                end
            end
        end else if (w_wa) begin
            r_mem[r_wp] <= entry_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= c_wp_init;
            r_rp    <= '0;
            r_count <= c_count_init;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_ra) begin
                r_rp <= r_rp + c_ptr_one;
            end
            case ({w_wa, w_ra})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
            // Sticky until reset; a rejected access sets them even if the
            // opposite port was accepted in the same cycle.
            if (wr && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign output_1 = w_empty ? '0 : r_mem[r_rp];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign ovf      = r_ovf;
    assign unf      = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_kpn_channel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_kpn_channel_fifo
// Brief    : Scoreboard bench for kpn_channel_fifo; two instances (no initial
//            tokens, and two initial tokens of 16'h1234) against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kpn_channel_fifo;

    localparam int c_depth = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s [2];
    logic        wr_s    [2];
    logic        rd_s    [2];
    logic [15:0] din_s   [2];
    logic [15:0] out_s   [2];
    logic        full_s  [2];
    logic        empty_s [2];
    logic [3:0]  cnt_s   [2];
    logic        ovf_s   [2];
    logic        unf_s   [2];

    kpn_channel_fifo #(
        .WIDTH(16), .DEPTH(c_depth), .INIT_TOKENS(0), .INIT_VALUE(16'h0000)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .wr(wr_s[0]), .entry_1(din_s[0]),
        .rd(rd_s[0]), .output_1(out_s[0]), .full(full_s[0]), .empty(empty_s[0]),
        .count(cnt_s[0]), .ovf(ovf_s[0]), .unf(unf_s[0])
    );

    kpn_channel_fifo #(
        .WIDTH(16), .DEPTH(c_depth), .INIT_TOKENS(2), .INIT_VALUE(16'h1234)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .wr(wr_s[1]), .entry_1(din_s[1]),
        .rd(rd_s[1]), .output_1(out_s[1]), .full(full_s[1]), .empty(empty_s[1]),
        .count(cnt_s[1]), .ovf(ovf_s[1]), .unf(unf_s[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: channel contents as plain queues plus sticky flags.
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit          ovm [2];
    bit          unm [2];
    // Scoreboard: tokens the consumer is expected to receive on each read.
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] mhead(input int k);
        if (msize(k) == 0) return 16'h0000;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset(input int k);
        if (k == 0) begin
            q0.delete();
        end else begin
            q1.delete();
            repeat (2) q1.push_back(16'h1234);
        end
        ovm[k] = 1'b0;
        unm[k] = 1'b0;
    endtask

    task automatic model_edge(input int k, input bit w, input bit r, input logic [15:0] d);
        int n = msize(k);
        if (w && n == c_depth) ovm[k] = 1'b1;
        if (r && n == 0)       unm[k] = 1'b1;
        if (r && n > 0) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (w && n < c_depth) begin
            if (k == 0) q0.push_back(d); else q1.push_back(d);
        end
    endtask

    task automatic check_state(input int k);
        int n = msize(k);
        chk($sformatf("count[%0d]", k), 32'(cnt_s[k]), 32'(n));
        chk($sformatf("full[%0d]", k),  32'(full_s[k]), 32'(n == c_depth));
        chk($sformatf("empty[%0d]", k), 32'(empty_s[k]), 32'(n == 0));
        chk($sformatf("ovf[%0d]", k),   32'(ovf_s[k]), 32'(ovm[k]));
        chk($sformatf("unf[%0d]", k),   32'(unf_s[k]), 32'(unm[k]));
        chk($sformatf("head[%0d]", k),  32'(out_s[k]), 32'(mhead(k)));
    endtask

    // One clock cycle on instance k (the other idles); reset when rst=1.
    task automatic step(input int k, input bit rst, input bit w, input bit r, input logic [15:0] d);
        @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            rst_n_s[j] = 1'b1;
            wr_s[j]    = 1'b0;
            rd_s[j]    = 1'b0;
        end
        rst_n_s[k] = ~rst;
        wr_s[k]    = w;
        rd_s[k]    = r;
        din_s[k]   = d;
        if (!rst && r && msize(k) > 0) begin
            if (k == 0) sb0.push_back(mhead(k)); else sb1.push_back(mhead(k));
        end
        @(negedge clk);
        check_state(0);
        check_state(1);
        if (rst) model_reset(k);
        else     model_edge(k, w, r, d);
    endtask

    task automatic idle(input int k);
        step(k, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic random_run(input int k, input int n);
        for (int p = 0; p < 4; p++) begin
            int wprob;
            wprob = (p == 0) ? 85 : (p == 1) ? 50 : (p == 2) ? 15 : 60;
            for (int i = 0; i < n; i++) begin
                step(k, 1'b0,
                     ($urandom_range(0, 99) < wprob),
                     ($urandom_range(0, 99) < (100 - wprob)),
                     16'($urandom));
            end
        end
    endtask

    // Monitor: every accepted read is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n_s[0] && rd_s[0] && !empty_s[0]) begin
            if (sb0.size() == 0) chk("rd_unexpected[0]", 32'(out_s[0]), 32'hFFFF_FFFF);
            else                 chk("rd_token[0]", 32'(out_s[0]), 32'(sb0.pop_front()));
        end
        if (rst_n_s[1] && rd_s[1] && !empty_s[1]) begin
            if (sb1.size() == 0) chk("rd_unexpected[1]", 32'(out_s[1]), 32'hFFFF_FFFF);
            else                 chk("rd_token[1]", 32'(out_s[1]), 32'(sb1.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 0; j < 2; j++) begin
            rst_n_s[j] = 1'b0;
            wr_s[j]    = 1'b0;
            rd_s[j]    = 1'b0;
            din_s[j]   = 16'h0000;
        end
        @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // Fill to capacity, then drain in order.
        for (int i = 1; i <= 8; i++) step(0, 1'b0, 1'b1, 1'b0, 16'(i));
        idle(0);
        repeat (8) step(0, 1'b0, 1'b0, 1'b1, 16'h0000);
        idle(0);

        // Overflow on a full channel, then write+read while full.
        for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, 1'b0, 16'(16'h0021 + i));
        step(0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        idle(0);
        step(0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        idle(0);
        repeat (7) step(0, 1'b0, 1'b0, 1'b1, 16'h0000);
        idle(0);

        // Write+read while empty: write lands, read is an underflow.
        step(0, 1'b0, 1'b1, 1'b1, 16'h00AA);
        idle(0);
        step(0, 1'b0, 1'b0, 1'b1, 16'h0000);
        idle(0);

        random_run(0, 100);

        // Reset a partially filled channel while a write is offered.
        step(0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 1'b0, 16'(16'h0050 + i));
        step(0, 1'b1, 1'b1, 1'b0, 16'hDEAD);
        idle(0);
        random_run(0, 25);
        repeat (9) step(0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Preloaded instance: reset state, then steady streaming with wrap.
        step(1, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(1);
        for (int i = 0; i < 20; i++) step(1, 1'b0, 1'b1, 1'b1, 16'(16'h0010 + i));
        idle(1);
        random_run(1, 60);
        step(1, 1'b1, 1'b1, 1'b0, 16'hCAFE);
        idle(1);
        random_run(1, 25);
        repeat (9) step(1, 1'b0, 1'b0, 1'b1, 16'h0000);
        idle(0);

        chk("sb_left[0]", 32'(sb0.size()), 32'd0);
        chk("sb_left[1]", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kpn_channel_fifo.md
# kpn_channel_fifo

Bounded FIFO channel connecting a producer process's `wr`/`entry_1` token stream to a consumer process's `rd`/`output_1` token stream in the KPN fabric. Tokens are 16-bit words and move in order. The block applies blocking-write/blocking-read semantics through `full`/`empty`. It can be preloaded at reset with initial tokens, which gives the network delay elements without dedicated delay processes.

## Interface
- `WIDTH`, 16: token width in bits.
- `DEPTH`, 8: channel capacity in tokens; power of two, ≥ 2.
- `INIT_TOKENS`, 0: tokens present after reset; 0..DEPTH.
- `INIT_VALUE`, 16'h0000: value of every initial token.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `wr`  in  1  producer write strobe; one token per cycle while high.
- `entry_1`  in  WIDTH  producer token, sampled when a write is accepted.
- `rd`  in  1  consumer read strobe; pops one token per cycle while high.
- `output_1`  out  WIDTH  head token (first-word fall-through).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  clog2(DEPTH+1)  tokens currently held.
- `ovf`  out  1  sticky: a write was attempted while full.
- `unf`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp`, read pointer `rp`, each clog2(DEPTH) bits, plus `count`. Pointers wrap modulo DEPTH naturally.
- Reset (`rst_n`=0 at an edge):
  - `rp`=0.
  - `wp`=INIT_TOKENS mod DEPTH.
  - `count`=INIT_TOKENS.
  - mem[0..INIT_TOKENS-1]=INIT_VALUE.
  - `ovf`=`unf`=0.
  - Reset overrides any `wr`/`rd` in the same cycle.
- Accept conditions, evaluated on the pre-edge state:
  - `wa` = `wr` & ~`full`
  - `ra` = `rd` & ~`empty`
- On `wa`: mem[`wp`]←`entry_1`, then `wp`++.
- On `ra`: `rp`++.
- Count update: `count` += `wa` − `ra`. Simultaneous `wa` & `ra` leaves `count` unchanged.
- Full with `wr` & `rd` in the same cycle: the read is accepted and the write is rejected (`full` is pre-edge), and `ovf` sets. The producer must retry.
- Empty with `wr` & `rd` in the same cycle: the write is accepted and the read is rejected, and `unf` sets. There is no bypass.
- Rejected accesses change no state except the sticky flags.
- `ovf` sets on `wr` & `full`; `unf` sets on `rd` & `empty`. Only reset clears them.
- `output_1` = mem[`rp`] when ~`empty`, else all zeros. The consumer samples `output_1` in the same cycle it asserts `rd`.
- `full`, `empty` and `count` derive combinationally from the registered `count` only. There is no combinational path from `wr`/`rd`.

## Timing
- Reset values:
  - `count`=INIT_TOKENS.
  - `empty`=(INIT_TOKENS==0).
  - `full`=(INIT_TOKENS==DEPTH).
  - `output_1`=INIT_VALUE if INIT_TOKENS>0, else 0.
  - `ovf`=`unf`=0.
- Write-to-read latency: a token written at edge N is visible on `output_1` and `empty` deasserts in the cycle after edge N. The earliest pop is at edge N+1.
- Read: after the pop at edge N, `output_1` shows the next token (or 0) in the cycle after edge N.
- Sustained throughput: one write and one read per cycle, indefinitely, at any occupancy of 1..DEPTH−1.
- Asserting reset mid-stream discards all held tokens and restores the initial tokens at the next edge.

## Test plan
- Reset with INIT_TOKENS=0, DEPTH=8; write 16'h0001..16'h0008 on 8 consecutive cycles.
  - Required: `full`=1 and `count`=8 after the 8th edge.
  - Then read 8 cycles: `output_1` sequence 1..8, then `empty`=1 and `output_1`=0.
- Full channel, `wr`=1 with `entry_1`=16'hBEEF for one cycle.
  - Required: `ovf`=1, `count` stays 8, head token unchanged.
- Full channel, `wr` & `rd` together.
  - Required: head popped, `count`=7, 16'hBEEF not stored, `ovf`=1.
- Empty channel, `wr` & `rd` together with `entry_1`=16'h00AA.
  - Required: `count`=1, `unf`=1; next cycle `output_1`=16'h00AA.
- INIT_TOKENS=2, INIT_VALUE=16'h1234.
  - After reset: `count`=2, `output_1`=16'h1234.
  - Stream 16'h0010.. with `wr`=`rd`=1 for 20 cycles: outputs are 1234, 1234, 0010, 0011, …; `count` stays 2, verifying pointer wrap-around.
- Partially filled channel (5 tokens), assert `rst_n`=0 for one edge while `wr`=1.
  - Required: `count`=INIT_TOKENS, sticky flags cleared, written token discarded.
